// File: rtl/i2c_ctrl.sv
// ---------------------------------------------------------------------------
// i2c_ctrl : byte-level I2C register read/write sequencer.
//
// Turns a single-cycle register write/read request into a sequence of
// bit-engine byte transfers (START/addr/reg/data/STOP). A bus-recovery
// STOP byte is issued on an address/register NACK. A per-byte watchdog
// aborts the transaction if the bit engine never completes.
//
// Ports
//   clk, rstn            system clock, async active-low reset
//   wr_req, rd_req       request pulses (write wins if both)
//   reg_addr, wdata      slave register address / write data
//   cmd, go, tx_data     bit-engine command (one-hot OR), start pulse, tx byte
//   trans_done, rx_data  bit-engine byte-complete pulse, received byte
//   ack_o                sampled slave ACK (0 = ACK, 1 = NACK)
//   rdata                read result, valid from rw_done until next accept
//   rw_done              one-cycle transaction-end pulse
//   ack_err, timeout_err status of the last transaction, valid with rw_done
//   busy                 transaction in progress
// ---------------------------------------------------------------------------
module i2c_ctrl #(
    parameter logic [6:0]  DEV_ADDR = 7'h51,
    parameter logic [15:0] TIMEOUT  = 16'd65535
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       wr_req,
    input  logic       rd_req,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [5:0] cmd,
    output logic       go,
    output logic [7:0] tx_data,
    input  logic       trans_done,
    input  logic [7:0] rx_data,
    input  logic       ack_o,
    output logic [7:0] rdata,
    output logic       rw_done,
    output logic       ack_err,
    output logic       timeout_err,
    output logic       busy
);

    // Bit-engine command bits (ACK = 6'b010000 exists but is never issued).
    localparam logic [5:0] C_WR   = 6'b000001;
    localparam logic [5:0] C_STA  = 6'b000010;
    localparam logic [5:0] C_RD   = 6'b000100;
    localparam logic [5:0] C_STO  = 6'b001000;
    localparam logic [5:0] C_NACK = 6'b100000;

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT, S_RECOVER, S_DONE
    } state_t;

    state_t      r_state;
    logic        r_rd;
    logic        r_recov;
    logic [1:0]  r_step;
    logic [7:0]  r_addr;
    logic [7:0]  r_wdata;
    logic [15:0] r_cnt;

    logic [15:0] w_cnt_nxt;
    logic [1:0]  w_step_nxt;
    logic        w_last;

    // {cmd, tx_data} for a given step of a write or read sequence.
    function automatic logic [13:0] f_step(input logic rd, input logic [1:0] st,
                                           input logic [7:0] ra, input logic [7:0] wd);
        case (st)
            2'd0:    f_step = {C_STA | C_WR, DEV_ADDR, 1'b0};
            2'd1:    f_step = {C_WR, ra};
            2'd2:    f_step = rd ? {C_STA | C_WR, DEV_ADDR, 1'b1} : {C_WR | C_STO, wd};
            default: f_step = {C_RD | C_NACK | C_STO, 8'h00};
        endcase
    endfunction

    assign w_cnt_nxt  = r_cnt + 16'd1;
    assign w_step_nxt = r_step + 2'd1;
    assign w_last     = r_rd ? (r_step == 2'd3) : (r_step == 2'd2);

    // go and rw_done are pulses: cleared every cycle unless set below.
    // The ISSUE/RECOVER state is the cycle in which go is high; the counter
    // is 0 in that cycle so the timeout fires TIMEOUT cycles after go.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_IDLE;
            r_rd        <= 1'b0;
            r_recov     <= 1'b0;
            r_step      <= 2'd0;
            r_addr      <= 8'h00;
            r_wdata     <= 8'h00;
            r_cnt       <= 16'd0;
            cmd         <= 6'd0;
            go          <= 1'b0;
            tx_data     <= 8'h00;
            rdata       <= 8'h00;
            rw_done     <= 1'b0;
            ack_err     <= 1'b0;
            timeout_err <= 1'b0;
            busy        <= 1'b0;
        end else begin
            go      <= 1'b0;
            rw_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (wr_req || rd_req) begin
                        r_rd            <= ~wr_req;
                        r_addr          <= reg_addr;
                        r_wdata         <= wdata;
                        r_step          <= 2'd0;
                        r_recov         <= 1'b0;
                        busy            <= 1'b1;
                        ack_err         <= 1'b0;
                        timeout_err     <= 1'b0;
                        {cmd, tx_data}  <= f_step(1'b0, 2'd0, reg_addr, wdata);
                        go              <= 1'b1;
                        r_cnt           <= 16'd0;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE, S_RECOVER: begin
                    r_cnt   <= w_cnt_nxt;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (trans_done) begin
                        if (r_recov) begin
                            rw_done <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end else if (cmd[0] && ack_o) begin
                            ack_err <= 1'b1;
                            if (cmd[3]) begin
                                rw_done <= 1'b1;
                                busy    <= 1'b0;
                                r_state <= S_DONE;
                            end else begin
                                // Release the bus with a dummy byte + STOP.
                                cmd     <= C_WR | C_STO;
                                tx_data <= 8'hFF;
                                go      <= 1'b1;
                                r_cnt   <= 16'd0;
                                r_recov <= 1'b1;
                                r_state <= S_RECOVER;
                            end
                        end else if (w_last) begin
                            if (r_rd) rdata <= rx_data;
                            rw_done <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_step         <= w_step_nxt;
                            {cmd, tx_data} <= f_step(r_rd, w_step_nxt, r_addr, r_wdata);
                            go             <= 1'b1;
                            r_cnt          <= 16'd0;
                            r_state        <= S_ISSUE;
                        end
                    end else if (w_cnt_nxt == TIMEOUT) begin
                        timeout_err <= 1'b1;
                        rw_done     <= 1'b1;
                        busy        <= 1'b0;
                        r_state     <= S_DONE;
                    end else begin
                        r_cnt <= w_cnt_nxt;
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_ctrl.sv
// ---------------------------------------------------------------------------
// tb_i2c_ctrl : self-checking bench for i2c_ctrl.
// A behavioural bit engine answers each go after a random delay with a
// scripted ACK pattern; expected byte sequences come from a list walk of the
// I2C register-access protocol.
// ---------------------------------------------------------------------------
module tb_i2c_ctrl;
    localparam int         TMO = 100;
    localparam logic [6:0] DA  = 7'h51;
    localparam logic [5:0] K_WR = 6'b000001, K_STA = 6'b000010, K_RD = 6'b000100,
                           K_STO = 6'b001000, K_NACK = 6'b100000;

    logic       clk = 1'b0, rstn = 1'b0, wr_req = 1'b0, rd_req = 1'b0;
    logic [7:0] reg_addr = 8'h00, wdata = 8'h00;
    logic [5:0] cmd;
    logic       go;
    logic [7:0] tx_data;
    logic       trans_done = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       ack_o = 1'b0;
    logic [7:0] rdata;
    logic       rw_done, ack_err, timeout_err, busy;

    always #5 clk = ~clk;

    i2c_ctrl #(.DEV_ADDR(DA), .TIMEOUT(16'(TMO))) dut (
        .clk(clk), .rstn(rstn), .wr_req(wr_req), .rd_req(rd_req),
        .reg_addr(reg_addr), .wdata(wdata), .cmd(cmd), .go(go), .tx_data(tx_data),
        .trans_done(trans_done), .rx_data(rx_data), .ack_o(ack_o), .rdata(rdata),
        .rw_done(rw_done), .ack_err(ack_err), .timeout_err(timeout_err), .busy(busy)
    );

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // bit-engine model / monitor state
    logic [4:0] ack_pat = 5'd0;
    int         hang_idx = -1;
    logic [7:0] rx_val = 8'h00;
    int         eng_idx = 0;
    bit         outstanding = 0, pend_hang = 0;
    logic       pend_ack = 1'b0;
    int         dly = 0;
    logic [5:0] out_cmd;
    logic [7:0] out_tx;
    int         overlap_err = 0, stable_err = 0;
    logic [5:0] gq_cmd[$];
    logic [7:0] gq_tx[$];
    int         gq_cyc[$];
    int         td_cyc[$];
    int         done_cnt = 0, d_cyc = 0;
    logic       d_ack, d_to, d_busy;
    logic [7:0] d_rdata;

    // expected results
    logic [5:0] exp_cmd[$];
    logic [7:0] exp_tx[$];
    logic       e_ack, e_to;
    logic [7:0] model_rdata = 8'h00;

    initial begin : engine
        forever begin
            @(posedge clk); #1;
            trans_done = 1'b0;
            ack_o      = 1'b0;
            if (!rstn) begin
                outstanding = 0;
            end else begin
                if (rw_done === 1'b1) begin
                    done_cnt++;
                    d_cyc = cyc; d_ack = ack_err; d_to = timeout_err;
                    d_busy = busy; d_rdata = rdata;
                    outstanding = 0;   // controller has abandoned any hung byte
                end
                if (outstanding && (cmd !== out_cmd || tx_data !== out_tx)) stable_err++;
                if (go === 1'b1) begin
                    if (outstanding) overlap_err++;
                    gq_cmd.push_back(cmd); gq_tx.push_back(tx_data); gq_cyc.push_back(cyc);
                    outstanding = 1; out_cmd = cmd; out_tx = tx_data;
                    dly       = $urandom_range(1, 4);
                    pend_ack  = (eng_idx < 5) ? ack_pat[eng_idx] : 1'b0;
                    pend_hang = (eng_idx == hang_idx);
                    eng_idx++;
                end else if (outstanding && !pend_hang) begin
                    dly--;
                    if (dly == 0) begin
                        trans_done = 1'b1; ack_o = pend_ack; rx_data = rx_val;
                        outstanding = 0; td_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not end, required end before time limit");
        $fatal(1);
    end

    // Protocol walk: emit bytes until a hang, a NACK, or the end.
    task automatic build_exp(input bit rd, input logic [7:0] a, input logic [7:0] d,
                             input logic [7:0] rx, input logic [4:0] ap, input int hg);
        logic [5:0] pc[4];
        logic [7:0] pt[4];
        int n;
        exp_cmd.delete(); exp_tx.delete();
        e_ack = 1'b0; e_to = 1'b0;
        pc[0] = K_STA | K_WR; pt[0] = {DA, 1'b0};
        pc[1] = K_WR;         pt[1] = a;
        if (rd) begin
            pc[2] = K_STA | K_WR;         pt[2] = {DA, 1'b1};
            pc[3] = K_RD | K_NACK | K_STO; pt[3] = 8'h00;
            n = 4;
        end else begin
            pc[2] = K_WR | K_STO; pt[2] = d;
            pc[3] = 6'd0;         pt[3] = 8'h00;
            n = 3;
        end
        for (int i = 0; i < n; i++) begin
            exp_cmd.push_back(pc[i]); exp_tx.push_back(pt[i]);
            if (i == hg) begin e_to = 1'b1; break; end
            if (pc[i][0] && ap[i]) begin
                e_ack = 1'b1;
                if (!pc[i][3]) begin
                    exp_cmd.push_back(K_WR | K_STO); exp_tx.push_back(8'hFF);
                    if (i + 1 == hg) e_to = 1'b1;
                end
                break;
            end
            if (i == n - 1 && rd) model_rdata = rx;
        end
    endtask

    task automatic run_txn(input string nm, input bit rd, input logic [7:0] a,
                           input logic [7:0] d, input logic [7:0] rx,
                           input logic [4:0] ap, input int hg, input bit both);
        int  d0, acc, nexp;
        bit  got;
        build_exp(rd, a, d, rx, ap, hg);
        @(posedge clk); #2;
        gq_cmd.delete(); gq_tx.delete(); gq_cyc.delete(); td_cyc.delete();
        eng_idx = 0; ack_pat = ap; hang_idx = hg; rx_val = rx; d0 = done_cnt;
        wr_req = !rd || both; rd_req = rd || both; reg_addr = a; wdata = d;
        @(posedge clk); #2;
        wr_req = 1'b0; rd_req = 1'b0; acc = cyc;
        if (both) begin
            @(posedge clk); #2; rd_req = 1'b1; reg_addr = ~a;
            @(posedge clk); #2; rd_req = 1'b0;
        end
        got = 0;
        for (int k = 0; k < 600 && !got; k++) begin
            @(posedge clk); #2;
            if (done_cnt != d0) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s rw_done: not seen within 600 cycles, required one pulse", nm);
            return;
        end
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++; $display("FAIL %s done_count: got %0d required 1", nm, done_cnt - d0);
        end
        nexp = exp_cmd.size();
        checks++;
        if (gq_cmd.size() !== nexp) begin
            errors++; $display("FAIL %s go_count: got %0d required %0d", nm, gq_cmd.size(), nexp);
        end
        for (int i = 0; i < nexp && i < gq_cmd.size(); i++) begin
            checks++;
            if (gq_cmd[i] !== exp_cmd[i] || gq_tx[i] !== exp_tx[i]) begin
                errors++;
                $display("FAIL %s byte%0d: got cmd %b tx %h required cmd %b tx %h",
                         nm, i, gq_cmd[i], gq_tx[i], exp_cmd[i], exp_tx[i]);
            end
        end
        if (gq_cyc.size() > 0) begin
            checks++;
            if (gq_cyc[0] !== acc) begin
                errors++; $display("FAIL %s first_go_cycle: got %0d required %0d", nm, gq_cyc[0], acc);
            end
        end
        for (int i = 1; i < gq_cyc.size() && i <= td_cyc.size(); i++) begin
            checks++;
            if (gq_cyc[i] !== td_cyc[i-1] + 1) begin
                errors++;
                $display("FAIL %s go%0d_cycle: got %0d required %0d", nm, i, gq_cyc[i], td_cyc[i-1] + 1);
            end
        end
        checks++;
        if (d_ack !== e_ack || d_to !== e_to || d_busy !== 1'b0) begin
            errors++;
            $display("FAIL %s status: got ack_err %b timeout_err %b busy %b required %b %b 0",
                     nm, d_ack, d_to, d_busy, e_ack, e_to);
        end
        checks++;
        if (d_rdata !== model_rdata) begin
            errors++; $display("FAIL %s rdata: got %h required %h", nm, d_rdata, model_rdata);
        end
        if (e_to && gq_cyc.size() > 0) begin
            checks++;
            if (d_cyc - gq_cyc[gq_cyc.size()-1] !== TMO) begin
                errors++;
                $display("FAIL %s timeout_latency: got %0d required %0d",
                         nm, d_cyc - gq_cyc[gq_cyc.size()-1], TMO);
            end
        end
    endtask

    task automatic check_reset_outs(input string nm);
        checks++;
        if (cmd !== 6'd0 || go !== 1'b0 || tx_data !== 8'h00 || rdata !== 8'h00 ||
            rw_done !== 1'b0 || ack_err !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: got cmd %b go %b tx %h rdata %h done %b ack %b to %b busy %b required all zero",
                     nm, cmd, go, tx_data, rdata, rw_done, ack_err, timeout_err, busy);
        end
    endtask

    task automatic test_reset();
        #3;
        check_reset_outs("reset_asserted");
        repeat (3) @(posedge clk);
        #2; rstn = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check_reset_outs("reset_released_idle");
        model_rdata = 8'h00;
    endtask

    task automatic test_write();
        run_txn("write", 1'b0, 8'h02, 8'h45, 8'h00, 5'b00000, -1, 1'b0);
    endtask

    task automatic test_read();
        run_txn("read", 1'b1, 8'h04, 8'h00, 8'h23, 5'b00000, -1, 1'b0);
    endtask

    task automatic test_addr_nack();
        run_txn("addr_nack_wr", 1'b0, 8'h10, 8'h99, 8'h00, 5'b00001, -1, 1'b0);
        run_txn("reg_nack_rd", 1'b1, 8'h11, 8'h00, 8'h5A, 5'b00110, -1, 1'b0);
        run_txn("data_nack_wr", 1'b0, 8'h12, 8'h34, 8'h00, 5'b00100, -1, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn("timeout_step0", 1'b0, 8'h20, 8'h01, 8'h00, 5'b00000, 0, 1'b0);
        run_txn("timeout_step2_rd", 1'b1, 8'h21, 8'h00, 8'h77, 5'b00000, 2, 1'b0);
    endtask

    task automatic test_simul();
        run_txn("simul_wr_rd", 1'b0, 8'h33, 8'hC3, 8'hEE, 5'b00000, -1, 1'b1);
    endtask

    task automatic test_reset_mid();
        int  d0;
        bit  hit;
        @(posedge clk); #2;
        gq_cmd.delete(); gq_tx.delete(); gq_cyc.delete(); td_cyc.delete();
        eng_idx = 0; ack_pat = 5'd0; hang_idx = -1; rx_val = 8'h66; d0 = done_cnt;
        rd_req = 1'b1; reg_addr = 8'h40;
        @(posedge clk); #2; rd_req = 1'b0;
        hit = 0;
        for (int k = 0; k < 200 && !hit; k++) begin
            @(posedge clk); #2;
            if (gq_cmd.size() >= 3) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++; $display("FAIL reset_mid reach_step2: not reached in 200 cycles, required step 2 go");
        end
        rstn = 1'b0;
        #1;
        check_reset_outs("reset_mid_outputs");
        repeat (2) @(posedge clk);
        #2; rstn = 1'b1;
        model_rdata = 8'h00;
        repeat (10) @(posedge clk);
        #2;
        checks++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid no_done: got done_delta %0d busy %b required 0 0", done_cnt - d0, busy);
        end
        run_txn("write_after_reset", 1'b0, 8'h41, 8'h5C, 8'h00, 5'b00000, -1, 1'b0);
    endtask

    task automatic test_random();
        logic [4:0] ap;
        for (int t = 0; t < 12; t++) begin
            ap = 5'd0;
            for (int b = 0; b < 5; b++) ap[b] = ($urandom_range(0, 5) == 0);
            run_txn("random", 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    8'($urandom), ap, -1, 1'b0);
        end
    endtask

    task automatic test_protocol();
        checks++;
        if (overlap_err !== 0 || stable_err !== 0) begin
            errors++;
            $display("FAIL protocol: got overlapping_go %0d unstable_cmd %0d required 0 0",
                     overlap_err, stable_err);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_addr_nack();
        test_timeout();
        test_simul();
        test_reset_mid();
        test_random();
        test_protocol();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
